// File: rtl/proc_trace_monitor_if.sv
// proc_trace_monitor_if: run-control, probe capture and trace readout bundle.
// Rev 1.0 - initial release
`default_nettype none

interface proc_trace_monitor_if #(
  parameter int NCH   = 4,
  parameter int W     = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             enable;
  logic             mode;
  logic [NCH*W-1:0] probe;
  logic             rd_req;
  logic             rd_ack;
  logic [NCH*W-1:0] rd_data;
  logic [31:0]      rd_cycle;
  logic [CW-1:0]    count;
  logic             halt;
  logic             overflow;

  modport master (
    output enable, mode, probe, rd_req,
    input  rd_ack, rd_data, rd_cycle, count, halt, overflow
  );

  modport slave (
    input  enable, mode, probe, rd_req,
    output rd_ack, rd_data, rd_cycle, count, halt, overflow
  );
endinterface

`default_nettype wire

// File: rtl/proc_trace_monitor.sv
// proc_trace_monitor: captures probe snapshots into a circular trace buffer
// for CYCLE_LIMIT active cycles, then drains them oldest-first. Rev 1.0
`default_nettype none

module proc_trace_monitor #(
  parameter int CYCLE_LIMIT = 50,
  parameter int NCH         = 4,
  parameter int W           = 32,
  parameter int DEPTH       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  proc_trace_monitor_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = AW + 1;
  localparam int          PW       = NCH * W;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [31:0] LAST_CYC = 32'(CYCLE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     cyc_q, cyc_d;
  logic            first_q, first_d;
  logic [PW-1:0]   last_probe_q, last_probe_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            halt_q, halt_d;
  logic            overflow_q, overflow_d;
  logic            rd_ack_q, rd_ack_d;
  logic [PW-1:0]   rd_data_q, rd_data_d;
  logic [31:0]     rd_cycle_q, rd_cycle_d;
  logic            active;
  logic            wr_en;

  logic [PW-1:0]   mem_probe_q [DEPTH];
  logic [31:0]     mem_cyc_q   [DEPTH];

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    first_d      = first_q;
    last_probe_d = last_probe_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    halt_d       = halt_q;
    overflow_d   = overflow_q;
    rd_ack_d     = 1'b0;
    rd_data_d    = rd_data_q;
    rd_cycle_d   = rd_cycle_q;
    active       = 1'b0;
    wr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        // The cycle that leaves IDLE is already RUN cycle 0.
        if (bus.enable) begin
          active  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.enable) active = 1'b1;
      end
      DONE: begin
        if (bus.rd_req && (count_q != '0)) begin
          rd_ack_d   = 1'b1;
          rd_data_d  = mem_probe_q[rd_ptr_q];
          rd_cycle_d = mem_cyc_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + AW'(1);
          count_d    = count_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (active) begin
      cyc_d   = cyc_q + 32'd1;
      first_d = 1'b0;
      if (!bus.mode || first_q || (bus.probe != last_probe_q)) begin
        wr_en        = 1'b1;
        last_probe_d = bus.probe;
        wr_ptr_d     = wr_ptr_q + AW'(1);
        // A full buffer drops its oldest entry to make room.
        if (count_q == FULL) begin
          rd_ptr_d   = rd_ptr_q + AW'(1);
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      if (cyc_q == LAST_CYC) begin
        state_d = DONE;
        halt_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      first_q      <= 1'b1;
      last_probe_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      halt_q       <= 1'b0;
      overflow_q   <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_data_q    <= '0;
      rd_cycle_q   <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      first_q      <= first_d;
      last_probe_q <= last_probe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      halt_q       <= halt_d;
      overflow_q   <= overflow_d;
      rd_ack_q     <= rd_ack_d;
      rd_data_q    <= rd_data_d;
      rd_cycle_q   <= rd_cycle_d;
    end
  end

  // Trace storage carries no reset; its contents are meaningless after reset.
  always_ff @(posedge clock) begin
    if (wr_en && reset) begin
      mem_probe_q[wr_ptr_q] <= bus.probe;
      mem_cyc_q[wr_ptr_q]   <= cyc_q;
    end
  end

  assign bus.rd_ack   = rd_ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_cycle = rd_cycle_q;
  assign bus.count    = count_q;
  assign bus.halt     = halt_q;
  assign bus.overflow = overflow_q;

endmodule

`default_nettype wire
